fixed_pt_divider: RTL and testbench
===================================

# fixed_pt_divider

Iterative signed fixed-point divider: the inverse operation to the fixed-point multiplier in the vector datapath. Computes `quotient = (dividend << DECIMAL_PLACE) / divisor` on two's-complement Q(OPERAND_WIDTH-DECIMAL_PLACE).DECIMAL_PLACE operands. Produces one quotient bit per clock using a restoring shift-subtract loop, behind a start/ready/done handshake. Sits beside the multiplier for vector normalisation and scaling on the Basys 3 (Artix-7) build.

## Interface

- OPERAND_WIDTH, 24: bit width of each operand and of the quotient.
- DECIMAL_PLACE, 12: binary point position, counted from the LSB.

- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only while ready=1.
- dividend  input  signed [OPERAND_WIDTH-1:0]  numerator; latched at accepted start.
- divisor  input  signed [OPERAND_WIDTH-1:0]  denominator; latched at accepted start.
- ready  output  1  idle and able to accept start.
- done  output  1  one-cycle pulse; quotient and flags valid.
- quotient  output  signed [OPERAND_WIDTH-1:0]  result; held until the next done.
- overflow  output  1  result magnitude exceeds the representable range; held with quotient.
- div_by_zero  output  1  divisor was 0; held with quotient.

## Operation

- States: IDLE, DIVIDE, FINISH.
- IDLE: ready=1. On start=1:
  - Latch the operand signs. Latch the magnitudes as OPERAND_WIDTH-bit unsigned values, so -2^(OPERAND_WIDTH-1) is handled.
  - Load the dividend magnitude left-shifted by DECIMAL_PLACE into a Q=OPERAND_WIDTH+DECIMAL_PLACE bit register.
  - Clear the partial remainder and the counter.
  - If divisor==0, go to FINISH. Otherwise go to DIVIDE.
- DIVIDE: each cycle, shift the remainder left by one and bring in the next dividend bit.
  - If remainder ≥ |divisor|, subtract |divisor| and set the quotient bit to 1.
  - Runs exactly Q cycles, then goes to FINISH.
- FINISH:
  - Negate the magnitude if the operand signs differ. Rounding is truncation toward zero.
  - Range check: positive results must have magnitude ≤ 2^(OPERAND_WIDTH-1)-1; negative results must have magnitude ≤ 2^(OPERAND_WIDTH-1).
  - Register quotient, overflow and div_by_zero. Pulse done and return to IDLE.
- Overflow and div_by_zero are mutually exclusive; div_by_zero takes priority.
- start while ready=0 is ignored; there is no queueing.
- Operand inputs are don't-care except in the accepted start cycle.

## Timing

- Reset: state=IDLE, ready=1, done=0, quotient=0, overflow=0, div_by_zero=0, internal registers cleared.
- Reset asserted mid-operation aborts the division immediately. No done pulse is produced for the aborted request.
- Start accepted at edge E0: ready=0 from E0. Edges E1..EQ iterate. Edge EQ+1 sets done=1 and ready=1.
  - Latency is Q+1 cycles from start to done: 37 at defaults.
- Divide-by-zero path: accepted at E0, done at E1 (latency 1 cycle).
- ready and done rise on the same edge. A start in the done cycle is accepted, giving back-to-back throughput of one result per Q+1 cycles.
- done is high for exactly one cycle.

## Configuration

- FIXED_PT_DIVIDER_SATURATE_EN defined:
  - Overflowing results clamp to 0x7FF…F (positive) or 0x800…0 (negative).
  - Divide-by-zero returns the clamp matching the dividend sign; a zero dividend clamps positive.
- Undefined:
  - Overflowing results wrap, returning the low OPERAND_WIDTH bits of the signed quotient.
  - Divide-by-zero returns 0.
- Flags are asserted identically in both builds.

## Test plan

- Defaults, 0x003000 (3.0) / 0x002000 (2.0) -> quotient 0x001800 (1.5), done 37 cycles after start, flags 0.
- 0xFFA000 (-6.0) / 0x004000 (4.0) -> 0xFFE800 (-1.5); also 0x001000 / 0x003000 -> 0x000555 (truncation toward zero).
- 0x7FF000 / 0x000001 -> overflow=1:
  - with SATURATE_EN, quotient 0x7FFFFF;
  - without, quotient 0x000000.
- 0x005000 / 0x000000 -> div_by_zero=1, done 1 cycle after start:
  - with SATURATE_EN, 0x7FFFFF;
  - without, 0x000000.
- Start pulsed during DIVIDE -> ignored, the first result is unchanged, and exactly one done is produced.
- rst asserted at iteration 10 -> ready=1 and all outputs 0 on the next cycle, no done. A fresh start then completes normally.

Source files
------------

// File: rtl/fixed_pt_divider.sv
// Iterative signed fixed-point divider (restoring, one quotient bit/clock).
// quotient = (dividend << DECIMAL_PLACE) / divisor, truncated toward zero.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start             request, sampled only while ready=1
//   dividend, divisor signed operands, latched on accepted start
//   ready             idle, able to accept start
//   done              one-cycle pulse, quotient/flags valid
//   quotient          signed result, held until next done
//   overflow          result magnitude out of range, held with quotient
//   div_by_zero       divisor was zero, held with quotient
//
// Build option: define FIXED_PT_DIVIDER_SATURATE_EN to clamp overflowing
// and divide-by-zero results instead of wrapping / returning zero.

module fixed_pt_divider #(
  parameter int OPERAND_WIDTH = 24,
  parameter int DECIMAL_PLACE = 12
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic signed [OPERAND_WIDTH-1:0] dividend,
  input  logic signed [OPERAND_WIDTH-1:0] divisor,
  output logic                            ready,
  output logic                            done,
  output logic signed [OPERAND_WIDTH-1:0] quotient,
  output logic                            overflow,
  output logic                            div_by_zero
);

  localparam int W  = OPERAND_WIDTH;
  localparam int Q  = OPERAND_WIDTH + DECIMAL_PLACE;
  localparam int CW = $clog2(Q + 1);

  localparam logic [CW-1:0] LAST = CW'(Q - 1);

  // Largest positive / negative magnitudes, widened to the quotient width.
  localparam logic [Q-1:0] POS_LIM = (Q'(1) << (W - 1)) - Q'(1);
  localparam logic [Q-1:0] NEG_LIM = Q'(1) << (W - 1);

  localparam logic [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    FINISH
  } state_t;

  state_t        state;
  logic [Q-1:0]  dvd_sr;
  logic [Q-1:0]  quo;
  logic [W-1:0]  rem;
  logic [W-1:0]  dvs_mag;
  logic [CW-1:0] cnt;
  logic          neg;
  logic          dvd_neg;
  logic          dz;

  // Operand magnitudes as unsigned W-bit values; the most negative
  // operand maps to 2^(W-1), which still fits unsigned.
  logic [W-1:0] dvd_u;
  logic [W-1:0] dvs_u;
  logic [W-1:0] dvd_mag_in;
  logic [W-1:0] dvs_mag_in;

  assign dvd_u = dividend;
  assign dvs_u = divisor;
  assign dvd_mag_in = dvd_u[W-1] ? (~dvd_u + W'(1)) : dvd_u;
  assign dvs_mag_in = dvs_u[W-1] ? (~dvs_u + W'(1)) : dvs_u;

  // One restoring step: shift in the next dividend bit and try to
  // subtract. The remainder stays below |divisor|, so W bits hold it
  // and only the shifted value needs the extra top bit.
  logic [W:0]   rem_sh;
  logic [W-1:0] rem_sub;
  logic         fits;

  assign rem_sh  = {rem, dvd_sr[Q-1]};
  assign fits    = rem_sh >= {1'b0, dvs_mag};
  assign rem_sub = rem_sh[W-1:0] - dvs_mag;

  // Result formatting for the FINISH state.
  logic [W-1:0] quo_neg;
  logic [W-1:0] wrap_val;
  logic [W-1:0] res_val;
  logic [W-1:0] dz_val;
  logic         ovf_c;

  assign quo_neg  = ~quo[W-1:0] + W'(1);
  assign wrap_val = neg ? quo_neg : quo[W-1:0];
  assign ovf_c    = neg ? (quo > NEG_LIM) : (quo > POS_LIM);

`ifdef FIXED_PT_DIVIDER_SATURATE_EN
  assign res_val = ovf_c ? (neg ? MIN_VAL : MAX_VAL) : wrap_val;
  assign dz_val  = dvd_neg ? MIN_VAL : MAX_VAL;
`else
  assign res_val = wrap_val;
  assign dz_val  = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ready       <= 1'b1;
      done        <= 1'b0;
      quotient    <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
      dvd_sr      <= '0;
      quo         <= '0;
      rem         <= '0;
      dvs_mag     <= '0;
      cnt         <= '0;
      neg         <= 1'b0;
      dvd_neg     <= 1'b0;
      dz          <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            ready   <= 1'b0;
            neg     <= dvd_u[W-1] ^ dvs_u[W-1];
            dvd_neg <= dvd_u[W-1];
            dvs_mag <= dvs_mag_in;
            dvd_sr  <= {dvd_mag_in, {DECIMAL_PLACE{1'b0}}};
            quo     <= '0;
            rem     <= '0;
            cnt     <= '0;
            dz      <= (dvs_u == '0);
            state   <= (dvs_u == '0) ? FINISH : DIVIDE;
          end
        end
        DIVIDE: begin
          dvd_sr <= dvd_sr << 1;
          quo    <= {quo[Q-2:0], fits};
          rem    <= fits ? rem_sub : rem_sh[W-1:0];
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            state <= FINISH;
          end
        end
        FINISH: begin
          if (dz) begin
            quotient    <= dz_val;
            overflow    <= 1'b0;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= res_val;
            overflow    <= ovf_c;
            div_by_zero <= 1'b0;
          end
          done  <= 1'b1;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_pt_divider.sv
// Self-checking bench for fixed_pt_divider: vector table, random vectors
// against a wide-integer model, plus back-to-back/ignore/reset sequences.

module tb_fixed_pt_divider;

`ifdef FIXED_PT_DIVIDER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [23:0] a;
    logic [23:0] b;
    logic [23:0] q;
    logic        ovf;
    logic        dz;
  } vec_t;

  typedef struct {
    logic [23:0] q;
    logic        ovf;
    logic        dz;
    int          sc;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [23:0] dividend;
  logic [23:0] divisor;
  logic        ready;
  logic        done;
  logic [23:0] quotient;
  logic        overflow;
  logic        div_by_zero;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ndone = 0;
  logic prev_done = 1'b0;
  exp_t sb[$];
  vec_t tbl[12];

  fixed_pt_divider dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .ready(ready),
    .done(done),
    .quotient(quotient),
    .overflow(overflow),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: every done pops the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      exp_t e;
      ndone++;
      chk("done_single_cycle", {31'd0, prev_done}, 32'd0);
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got done expected none");
      end else begin
        e = sb.pop_front();
        chk("quotient", {8'd0, quotient}, {8'd0, e.q});
        chk("overflow", {31'd0, overflow}, {31'd0, e.ovf});
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
        chk("latency", cyc - e.sc, e.lat);
      end
    end
    prev_done = done;
  end

  function automatic void model(input logic [23:0] a, input logic [23:0] b,
                                output logic [23:0] q, output logic ovf,
                                output logic dz);
    longint n;
    longint d;
    longint r;
    if (b == 24'd0) begin
      dz  = 1'b1;
      ovf = 1'b0;
      q   = SAT ? (a[23] ? 24'h800000 : 24'h7FFFFF) : 24'h000000;
    end else begin
      dz  = 1'b0;
      n   = longint'($signed(a)) * 64'sd4096;
      d   = longint'($signed(b));
      r   = n / d;
      ovf = (r > 64'sd8388607) || (r < -64'sd8388608);
      if (ovf && SAT) q = (r > 0) ? 24'h7FFFFF : 24'h800000;
      else q = r[23:0];
    end
  endfunction

  task automatic launch(input vec_t v);
    exp_t e;
    int   n = 0;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_start", {31'd0, ready}, 32'd1);
    dividend = v.a;
    divisor  = v.b;
    start    = 1'b1;
    e.q   = v.q;
    e.ovf = v.ovf;
    e.dz  = v.dz;
    e.sc  = cyc + 1;
    e.lat = v.dz ? 1 : 37;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 24'($urandom);
    divisor  = 24'($urandom);
    chk("ready_low_after_accept", {31'd0, ready}, 32'd0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("result_timeout", sb.size(), 32'd0);
    sb.delete();
    @(negedge clk);
  endtask

  task automatic chk_cleared(input string nm);
    chk({nm, "_ready"}, {31'd0, ready}, 32'd1);
    chk({nm, "_done"}, {31'd0, done}, 32'd0);
    chk({nm, "_quotient"}, {8'd0, quotient}, 32'd0);
    chk({nm, "_overflow"}, {31'd0, overflow}, 32'd0);
    chk({nm, "_div_by_zero"}, {31'd0, div_by_zero}, 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   d0;
    int   n;

    tbl[0]  = '{24'h003000, 24'h002000, 24'h001800, 1'b0, 1'b0};
    tbl[1]  = '{24'hFFA000, 24'h004000, 24'hFFE800, 1'b0, 1'b0};
    tbl[2]  = '{24'h001000, 24'h003000, 24'h000555, 1'b0, 1'b0};
    tbl[3]  = '{24'h7FF000, 24'h000001,
                SAT ? 24'h7FFFFF : 24'h000000, 1'b1, 1'b0};
    tbl[4]  = '{24'h005000, 24'h000000,
                SAT ? 24'h7FFFFF : 24'h000000, 1'b0, 1'b1};
    tbl[5]  = '{24'h800000, 24'h001000, 24'h800000, 1'b0, 1'b0};
    tbl[6]  = '{24'h800000, 24'hFFF000,
                SAT ? 24'h7FFFFF : 24'h800000, 1'b1, 1'b0};
    tbl[7]  = '{24'hFFD000, 24'h000000,
                SAT ? 24'h800000 : 24'h000000, 1'b0, 1'b1};
    tbl[8]  = '{24'h000000, 24'h000000,
                SAT ? 24'h7FFFFF : 24'h000000, 1'b0, 1'b1};
    tbl[9]  = '{24'h7FFFFF, 24'h001000, 24'h7FFFFF, 1'b0, 1'b0};
    tbl[10] = '{24'hFFF000, 24'h003000, 24'hFFFAAB, 1'b0, 1'b0};
    tbl[11] = '{24'h001000, 24'hFFFFFF,
                SAT ? 24'h800000 : 24'h000000, 1'b1, 1'b0};

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    chk_cleared("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      launch(tbl[i]);
      wait_idle();
    end

    for (int i = 0; i < 10; i++) begin
      v.a = 24'($urandom);
      if (i == 7) v.b = 24'd0;
      else if (i % 3 == 0) v.b = 24'($urandom_range(1, 255));
      else v.b = 24'($urandom);
      model(v.a, v.b, v.q, v.ovf, v.dz);
      launch(v);
      wait_idle();
    end

    // Back-to-back: second start lands in the done cycle of the first.
    launch(tbl[1]);
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_first_done", {31'd0, done}, 32'd1);
    launch(tbl[10]);
    wait_idle();

    // Start while busy must be ignored.
    d0 = ndone;
    launch(tbl[2]);
    repeat (5) @(negedge clk);
    dividend = 24'h7FF000;
    divisor  = 24'h000001;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();
    repeat (40) @(negedge clk);
    chk("ignored_start_done_count", ndone - d0, 32'd1);

    // Reset at iteration 10 aborts without a done.
    launch(tbl[9]);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    d0 = ndone;
    @(negedge clk);
    chk_cleared("midop_reset");
    rst = 1'b0;
    repeat (45) @(negedge clk);
    chk("abort_no_done", ndone - d0, 32'd0);
    launch(tbl[0]);
    wait_idle();
    chk("fresh_after_reset_done", ndone - d0, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
